// File: rtl/nibble_serial_addsub_pkg.sv
// rtl/nibble_serial_addsub_pkg.sv - shared types and constants for the nibble-serial add/sub controller
package nibble_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// rtl/nibble_serial_addsub_slice.sv - combinational 4-bit add/sub slice with carry in/out
module nibble_addsub_slice
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ctrl,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] b_eff;

    assign b_eff     = (ctrl == OP_SUB) ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - multi-cycle W-bit add/sub sequencing one nibble slice LSB-first
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] result,
    output logic                     cout,
    output logic                     overflow
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           op_q;
    logic [IW-1:0]  idx;
    logic           c;

    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] s;
    logic             co;
    logic             last;
    logic             b_top_eff;

    // Current nibble is brought down to bit 0 so the slice sees a fixed 4-bit window
    assign a_sh      = a_q >> {idx, 2'b00};
    assign b_sh      = b_q >> {idx, 2'b00};
    assign a_nib     = a_sh[NIB_W-1:0];
    assign b_nib     = b_sh[NIB_W-1:0];
    assign last      = (idx == IW'(NIBBLES - 1));
    assign b_top_eff = (op_q == OP_SUB) ? ~b_nib[NIB_W-1] : b_nib[NIB_W-1];

    nibble_addsub_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .ctrl (op_q),
        .cin  (c),
        .s    (s),
        .cout (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            idx      <= '0;
            c        <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        idx   <= '0;
                        // Seeding the carry with op supplies the +1 of a + ~b + 1
                        c     <= op;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IW'(i)) begin
                            result[NIB_W*i +: NIB_W] <= s;
                        end
                    end
                    c   <= co;
                    idx <= idx + 1'b1;
                    if (last) begin
                        cout     <= co;
                        overflow <= (a_nib[NIB_W-1] == b_top_eff) && (s[NIB_W-1] != a_nib[NIB_W-1]);
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
